// File: rtl/avr_progmem_ctrl_if.sv
// Bus bundle between the program-memory controller, the CPU fetch/LPM ports, the loader and the RAM.
// LPM signals exist only when AVR_PROGMEM_LPM_EN is defined.
interface avr_progmem_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
);
    logic                  prog_en;
    logic                  cpu_rst;

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_stall;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;

`ifdef AVR_PROGMEM_LPM_EN
    logic                  lpm_req;
    logic [ADDR_WIDTH-1:0] lpm_addr;
    logic                  lpm_stall;
    logic                  lpm_valid;
    logic [DATA_WIDTH-1:0] lpm_data;
`endif

    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ack;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Controller side
    modport slave (
`ifdef AVR_PROGMEM_LPM_EN
        input  lpm_req, lpm_addr,
        output lpm_stall, lpm_valid, lpm_data,
`endif
        input  prog_en, fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_rdata,
        output cpu_rst, fetch_stall, fetch_valid, fetch_data, ld_ack,
        output mem_addr, mem_wdata, mem_we
    );

    // CPU, loader and RAM side
    modport master (
`ifdef AVR_PROGMEM_LPM_EN
        output lpm_req, lpm_addr,
        input  lpm_stall, lpm_valid, lpm_data,
`endif
        output prog_en, fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_rdata,
        input  cpu_rst, fetch_stall, fetch_valid, fetch_data, ld_ack,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/avr_progmem_ctrl.sv
// Program-memory sequencer/arbiter: CPU fetch, optional LPM reads (AVR_PROGMEM_LPM_EN) and loader writes
// share one single-port RAM; the CPU is held in reset while the loader owns the memory.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RELEASE | one-cycle gap after reset or programming, CPU still in reset
// ST_RUN     | CPU running, reads arbitrated (LPM over fetch)
// ST_PROG    | loader owns memory, writes issued on ld_req, CPU in reset
module avr_progmem_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    avr_progmem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RELEASE = 2'd0,
        ST_RUN     = 2'd1,
        ST_PROG    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  read_open;
    logic                  fetch_grant;
    logic                  lpm_grant;
    logic                  wr_issue;
    logic                  cpu_rst_q;
    logic                  fetch_valid_q;
    logic                  lpm_valid_q;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_RELEASE;
            cpu_rst_q     <= 1'b1;
            fetch_valid_q <= 1'b0;
            lpm_valid_q   <= 1'b0;
        end else begin
            state         <= state_nxt;
            cpu_rst_q     <= (state_nxt != ST_RUN);
            fetch_valid_q <= fetch_grant;
            lpm_valid_q   <= lpm_grant;
        end
    end

    always_comb begin
        state_nxt   = state;
        read_open   = 1'b0;
        wr_issue    = 1'b0;
        fetch_grant = 1'b0;
        lpm_grant   = 1'b0;

        case (state)
            ST_RELEASE: state_nxt = bus.prog_en ? ST_PROG : ST_RUN;
            ST_RUN: begin
                if (bus.prog_en) begin
                    state_nxt = ST_PROG;
                end else begin
                    read_open = 1'b1;
                end
            end
            ST_PROG: begin
                wr_issue = bus.ld_req;
                // A write pending alongside the prog_en fall keeps us here one more cycle
                if (!bus.prog_en && !bus.ld_req) begin
                    state_nxt = ST_RELEASE;
                end
            end
            default: state_nxt = ST_RELEASE;
        endcase

`ifdef AVR_PROGMEM_LPM_EN
        lpm_grant   = read_open && bus.lpm_req;
        fetch_grant = read_open && bus.fetch_req && !bus.lpm_req;
`else
        fetch_grant = read_open && bus.fetch_req;
`endif
    end

    always_comb begin
        addr_mux = bus.fetch_addr;
        if (wr_issue) begin
            addr_mux = bus.ld_addr;
        end
`ifdef AVR_PROGMEM_LPM_EN
        else if (lpm_grant) begin
            addr_mux = bus.lpm_addr;
        end
`endif
    end

    assign rdata           = bus.mem_rdata;

    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.mem_addr    = addr_mux;
    assign bus.mem_wdata   = bus.ld_data;
    assign bus.mem_we      = wr_issue;
    assign bus.ld_ack      = wr_issue;

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = rdata;

`ifdef AVR_PROGMEM_LPM_EN
    assign bus.fetch_stall = !read_open || bus.lpm_req;
    assign bus.lpm_stall   = !read_open;
    assign bus.lpm_valid   = lpm_valid_q;
    assign bus.lpm_data    = rdata;
`else
    assign bus.fetch_stall = !read_open;
`endif

endmodule

// File: tb/tb_avr_progmem_ctrl.sv
// Bench for avr_progmem_ctrl: behavioural ownership/scoreboard model checked every cycle, plus directed literals.
// Builds with or without AVR_PROGMEM_LPM_EN.
module tb_avr_progmem_ctrl;

    localparam int AW = 9;
    localparam int DW = 16;

    logic clk;
    logic rst;
    logic ram_load;

    int n_cmp;
    int n_err;

    avr_progmem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pm ();

    avr_progmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program RAM: one-cycle registered read, initial contents A000|addr
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= 16'hA000 | 16'(i);
        end else begin
            if (pm.mem_we) ram[pm.mem_addr] <= pm.mem_wdata;
            pm.mem_rdata <= ram[pm.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the memory (0 = gap after reset/programming, 1 = CPU, 2 = loader),
    // a shadow copy of the program and the read expected back next cycle.
    int            owner;
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic          pend_f, pend_l;
    logic [DW-1:0] pend_fd, pend_ld;
    logic          m_run, m_gf, m_gl, m_we, m_lreq;

    initial begin
        owner  = 0;
        pend_f = 1'b0;
        pend_l = 1'b0;
    end

    always @(negedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < (1 << AW); i++) shadow[i] = 16'hA000 | 16'(i);
        end
        if (rst) begin
            chk("m_rst_cpu_rst", 32'(pm.cpu_rst), 32'd1);
            chk("m_rst_fetch_valid", 32'(pm.fetch_valid), 32'd0);
            chk("m_rst_fetch_stall", 32'(pm.fetch_stall), 32'd1);
            chk("m_rst_ld_ack", 32'(pm.ld_ack), 32'd0);
            chk("m_rst_mem_we", 32'(pm.mem_we), 32'd0);
`ifdef AVR_PROGMEM_LPM_EN
            chk("m_rst_lpm_valid", 32'(pm.lpm_valid), 32'd0);
            chk("m_rst_lpm_stall", 32'(pm.lpm_stall), 32'd1);
`endif
            owner  = 0;
            pend_f = 1'b0;
            pend_l = 1'b0;
        end else begin
`ifdef AVR_PROGMEM_LPM_EN
            m_lreq = pm.lpm_req;
`else
            m_lreq = 1'b0;
`endif
            m_run = (owner == 1) && !pm.prog_en;
            m_gl  = m_run && m_lreq;
            m_gf  = m_run && pm.fetch_req && !m_lreq;
            m_we  = (owner == 2) && pm.ld_req;

            chk("m_cpu_rst", 32'(pm.cpu_rst), 32'(owner != 1));
            chk("m_fetch_stall", 32'(pm.fetch_stall), 32'(!m_run || m_lreq));
            chk("m_ld_ack", 32'(pm.ld_ack), 32'(m_we));
            chk("m_mem_we", 32'(pm.mem_we), 32'(m_we));
            chk("m_fetch_valid", 32'(pm.fetch_valid), 32'(pend_f));
            if (pend_f) chk("m_fetch_data", 32'(pm.fetch_data), 32'(pend_fd));
`ifdef AVR_PROGMEM_LPM_EN
            chk("m_lpm_stall", 32'(pm.lpm_stall), 32'(!m_run));
            chk("m_lpm_valid", 32'(pm.lpm_valid), 32'(pend_l));
            if (pend_l) chk("m_lpm_data", 32'(pm.lpm_data), 32'(pend_ld));
            if (m_gl) chk("m_mem_addr_lpm", 32'(pm.mem_addr), 32'(pm.lpm_addr));
            pend_ld = shadow[pm.lpm_addr];
`else
            pend_ld = '0;
`endif
            if (m_gf) chk("m_mem_addr_fetch", 32'(pm.mem_addr), 32'(pm.fetch_addr));
            if (m_we) begin
                chk("m_mem_addr_wr", 32'(pm.mem_addr), 32'(pm.ld_addr));
                chk("m_mem_wdata", 32'(pm.mem_wdata), 32'(pm.ld_data));
            end

            pend_f  = m_gf;
            pend_l  = m_gl;
            pend_fd = shadow[pm.fetch_addr];
            if (m_we) shadow[pm.ld_addr] = pm.ld_data;

            if (owner == 0)      owner = pm.prog_en ? 2 : 1;
            else if (owner == 1) owner = pm.prog_en ? 2 : 1;
            else if (!pm.prog_en && !pm.ld_req) owner = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        ram_load = 1'b1;
        pm.prog_en = 1'b0;
        pm.fetch_req = 1'b0;
        pm.fetch_addr = '0;
        pm.ld_req = 1'b0;
        pm.ld_addr = '0;
        pm.ld_data = '0;
`ifdef AVR_PROGMEM_LPM_EN
        pm.lpm_req = 1'b0;
        pm.lpm_addr = '0;
`endif
        tick();
        tick();
        ram_load = 1'b0;
        at_mid();
        chk("reset_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        chk("reset_fetch_valid", 32'(pm.fetch_valid), 32'd0);
        chk("reset_ld_ack", 32'(pm.ld_ack), 32'd0);
        chk("reset_mem_we", 32'(pm.mem_we), 32'd0);
        chk("reset_fetch_stall", 32'(pm.fetch_stall), 32'd1);

        // Release and a three-word fetch stream
        tick(); rst = 1'b0;
        at_mid(); chk("release_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick(); pm.fetch_req = 1'b1; pm.fetch_addr = 9'd0;
        at_mid(); chk("run_cpu_rst", 32'(pm.cpu_rst), 32'd0);
        tick(); pm.fetch_addr = 9'd1;
        at_mid(); chk("stream0_valid", 32'(pm.fetch_valid), 32'd1);
        chk("stream0_data", 32'(pm.fetch_data), 32'hA000);
        tick(); pm.fetch_addr = 9'd2;
        at_mid(); chk("stream1_data", 32'(pm.fetch_data), 32'hA001);
        tick(); pm.fetch_req = 1'b0;
        at_mid(); chk("stream2_data", 32'(pm.fetch_data), 32'hA002);
        tick();
        at_mid(); chk("stream_end_valid", 32'(pm.fetch_valid), 32'd0);

        // Loader request while the CPU runs is ignored
        tick(); pm.ld_req = 1'b1; pm.ld_addr = 9'h0AA; pm.ld_data = 16'h1234;
        for (int k = 0; k < 10; k++) begin
            at_mid();
            chk("run_ld_ack", 32'(pm.ld_ack), 32'd0);
            chk("run_mem_we", 32'(pm.mem_we), 32'd0);
            tick();
        end
        pm.ld_req = 1'b0;

        // Programming session with two back-to-back writes
        pm.prog_en = 1'b1; pm.fetch_req = 1'b1; pm.fetch_addr = 9'd3;
        at_mid(); chk("prog_req_stall", 32'(pm.fetch_stall), 32'd1);
        chk("prog_req_cpu_rst", 32'(pm.cpu_rst), 32'd0);
        tick(); pm.fetch_req = 1'b0;
        at_mid(); chk("prog_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick(); pm.ld_req = 1'b1; pm.ld_addr = 9'h010; pm.ld_data = 16'h9508;
        at_mid(); chk("wr0_ack", 32'(pm.ld_ack), 32'd1);
        chk("wr0_we", 32'(pm.mem_we), 32'd1);
        chk("wr0_addr", 32'(pm.mem_addr), 32'h010);
        tick(); pm.ld_addr = 9'h1FF; pm.ld_data = 16'h940C;
        at_mid(); chk("wr1_ack", 32'(pm.ld_ack), 32'd1);
        chk("wr1_we", 32'(pm.mem_we), 32'd1);
        tick(); pm.ld_req = 1'b0; pm.prog_en = 1'b0;
        at_mid(); chk("prog_last_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick();
        at_mid(); chk("gap_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick(); pm.fetch_req = 1'b1; pm.fetch_addr = 9'h1FF;
        at_mid(); chk("rerun_cpu_rst", 32'(pm.cpu_rst), 32'd0);
        tick(); pm.fetch_addr = 9'h010;
        at_mid(); chk("rd_1ff", 32'(pm.fetch_data), 32'h940C);
        tick(); pm.fetch_req = 1'b0;
        at_mid(); chk("rd_010", 32'(pm.fetch_data), 32'h9508);
        tick();

`ifdef AVR_PROGMEM_LPM_EN
        // LPM beats fetch, fetch follows next cycle
        pm.lpm_req = 1'b1; pm.lpm_addr = 9'h020; pm.fetch_req = 1'b1; pm.fetch_addr = 9'h005;
        at_mid(); chk("arb_fetch_stall", 32'(pm.fetch_stall), 32'd1);
        chk("arb_lpm_stall", 32'(pm.lpm_stall), 32'd0);
        chk("arb_mem_addr", 32'(pm.mem_addr), 32'h020);
        tick(); pm.lpm_req = 1'b0;
        at_mid(); chk("arb_lpm_valid", 32'(pm.lpm_valid), 32'd1);
        chk("arb_lpm_data", 32'(pm.lpm_data), 32'hA020);
        chk("arb_fetch_granted", 32'(pm.fetch_stall), 32'd0);
        tick(); pm.fetch_req = 1'b0;
        at_mid(); chk("arb_fetch_valid", 32'(pm.fetch_valid), 32'd1);
        chk("arb_fetch_data", 32'(pm.fetch_data), 32'hA005);
        tick();
`endif

        // prog_en falls together with a write
        pm.prog_en = 1'b1;
        at_mid();
        tick();
        at_mid(); chk("p2_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick(); pm.prog_en = 1'b0; pm.ld_req = 1'b1; pm.ld_addr = 9'h030; pm.ld_data = 16'hBEEF;
        at_mid(); chk("fall_wr_ack", 32'(pm.ld_ack), 32'd1);
        chk("fall_wr_we", 32'(pm.mem_we), 32'd1);
        tick(); pm.ld_req = 1'b0;
        at_mid(); chk("fall_hold_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick();
        at_mid(); chk("fall_gap_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick(); pm.fetch_req = 1'b1; pm.fetch_addr = 9'h030;
        at_mid(); chk("fall_run_cpu_rst", 32'(pm.cpu_rst), 32'd0);
        tick(); pm.fetch_req = 1'b0;
        at_mid(); chk("rd_030", 32'(pm.fetch_data), 32'hBEEF);
        tick();

        // Reset with a read in flight
        pm.fetch_req = 1'b1; pm.fetch_addr = 9'd7;
        tick(); pm.fetch_req = 1'b0;
        #1 chk("inflight_valid", 32'(pm.fetch_valid), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_run_valid", 32'(pm.fetch_valid), 32'd0);
        chk("rst_run_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick(); rst = 1'b0;
        at_mid(); chk("rst_run_release", 32'(pm.cpu_rst), 32'd1);
        tick();
        at_mid(); chk("rst_run_resume", 32'(pm.cpu_rst), 32'd0);

        // Reset mid-PROG with a write pending
        tick(); pm.prog_en = 1'b1;
        tick(); pm.ld_req = 1'b1; pm.ld_addr = 9'h040; pm.ld_data = 16'h1111;
        #1 chk("pend_ack", 32'(pm.ld_ack), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rstp_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        chk("rstp_ld_ack", 32'(pm.ld_ack), 32'd0);
        chk("rstp_mem_we", 32'(pm.mem_we), 32'd0);
        chk("rstp_fetch_valid", 32'(pm.fetch_valid), 32'd0);
        tick(); rst = 1'b0;
        at_mid(); chk("rstp_release_ack", 32'(pm.ld_ack), 32'd0);
        chk("rstp_release_cpu_rst", 32'(pm.cpu_rst), 32'd1);
        tick();
        at_mid(); chk("rstp_prog_ack", 32'(pm.ld_ack), 32'd1);
        tick(); pm.ld_req = 1'b0; pm.prog_en = 1'b0;
        tick();
        tick(); pm.fetch_req = 1'b1; pm.fetch_addr = 9'h040;
        at_mid(); chk("rstp_run_cpu_rst", 32'(pm.cpu_rst), 32'd0);
        tick(); pm.fetch_req = 1'b0;
        at_mid(); chk("rd_040", 32'(pm.fetch_data), 32'h1111);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
